morse_tx: RTL
=============

Name: morse_tx

Overview:
- Serial keying stage directly downstream of the Morse coder `cd`.
- Accepts one 24-bit Morse code word per character over a valid/ready handshake.
- Plays the code word out as a timed on/off `key` line with standard Morse proportions: dot 1 unit, dash 3, element gap 1, character gap 3, word gap 7.
- Provides the physical transmit output for the ROM -> `cd` chain.

Parameters:
- UNIT_CYCLES, 4: clk cycles per Morse time unit; must be >= 1.
- MAX_SYM, 12: symbol slots per code word (24 bits / 2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  stage enable; low freezes all state, timers and outputs.
- x_valid  input  1  code word on `x` is valid.
- x  input  24  code word from `cd`.
- x_ready  output  1  stage can accept a code word this cycle.
- key  output  1  Morse key line, 1 = tone on.
- busy  output  1  a character or word gap is in progress.
- done  output  1  one-cycle pulse when a character or word gap completes.

Behaviour:
- Reset and single clock:
  - One clock `clk`; reset `rst` is synchronous and active-high.
  - While `rst` = 1 at a clk edge: state IDLE, key = 0, busy = 0, done = 0, shift register and timers cleared.
  - x_ready = 0 during the reset cycle.
- Code word format:
  - x[23:0] holds 12 two-bit symbols, MSB first, left-aligned.
  - 2'b01 = dot, 2'b11 = dash.
  - 2'b00 or 2'b10 = end of character; all following slots are ignored.
  - x == 0 is the word separator (space).
- Handshake:
  - x_ready = en & (state == IDLE) & ~rst, combinational.
  - Transfer occurs on a clk edge with x_valid & x_ready; x is latched into a 24-bit shift register.
  - x_valid without x_ready is held off; no word is lost or duplicated.
- States: IDLE, ELEM_ON, ELEM_GAP, CHAR_GAP, WORD_GAP.
  - IDLE -> ELEM_ON on accept when the first symbol is a dot or dash. key rises on the accept edge, so key = 1 in the first cycle after acceptance (latency 1).
  - IDLE -> WORD_GAP on accept of x == 0.
  - IDLE -> CHAR_GAP on accept of a nonzero word whose first symbol is a terminator (malformed word; only the char gap is played).
  - ELEM_ON: key = 1 for 1*UNIT_CYCLES (dot) or 3*UNIT_CYCLES (dash) cycles. Then shift left by 2.
    - If the next symbol is a dot/dash and fewer than MAX_SYM symbols have been sent -> ELEM_GAP.
    - Otherwise -> CHAR_GAP.
  - ELEM_GAP: key = 0 for 1*UNIT_CYCLES -> ELEM_ON.
  - CHAR_GAP: key = 0 for 3*UNIT_CYCLES -> IDLE; done = 1 in the last gap cycle.
  - WORD_GAP: key = 0 for 7*UNIT_CYCLES -> IDLE; done = 1 in the last gap cycle.
- Outputs:
  - busy = (state != IDLE), registered with state.
  - key is registered and glitch-free.
- Timing counter:
  - Unit prescaler counts 0..UNIT_CYCLES-1 and ticks on the last count.
  - Unit counter of 3 bits counts ticks up to the required length (1/3/7).
  - Both counters reset on every state entry.
- en = 0: the prescaler, unit counter, state and shift register hold; key, busy and done hold; x_ready = 0. Resuming en continues exactly where it stopped.
- Back-to-back operation: the next word may be accepted in the cycle immediately after done (IDLE). There is no extra dead cycle beyond the gaps.
- Reset mid-character: aborts immediately. key = 0 on the next cycle, no done pulse, the partial word is discarded.
- A 12th symbol that is a dot/dash is sent, then CHAR_GAP follows without any lookahead past bit 0.

Decomposition:
- Package `morse_pkg`:
  - Symbol codes SYM_DOT = 2'b01, SYM_DASH = 2'b11.
  - Unit lengths DOT_U = 1, DASH_U = 3, ELEM_GAP_U = 1, CHAR_GAP_U = 3, WORD_GAP_U = 7.
  - State enum typedef and code word width 24, shared with `cd` and `dc`.
- Sub-module `morse_unit_timer`:
  - Prescaler plus unit counter.
  - Inputs: clk, rst, en, restart, len_units[2:0].
  - Output: expire.
- The FSM and shift register stay in `morse_tx`.

Test Plan (UNIT_CYCLES = 2):
- 'E': x = 24'h400000 accepted -> key = 1 for 2 cycles starting 1 cycle after accept, then 0 for 6 cycles; done pulse on the 6th low cycle; x_ready = 1 on the next cycle.
- 'A': x = 24'h700000 -> key pattern 1×2, 0×2, 1×6, 0×6; one done pulse; busy high for exactly 16 cycles.
- Space then 'T': x = 24'h000000, then x = 24'hC00000 held valid -> key low for 14 cycles with done; 'T' accepted on the next cycle; key high for 6 cycles.
- Full word: x = 24'h555555 (12 dots) -> 12 pulses of 2 high separated by 2 low, then 6 low; done once; total busy = 52 cycles.
- en freeze: deassert en for 5 cycles in the middle of a dash -> key stays 1 and the dash lasts 6 + 5 = 11 cycles; x_ready = 0 while en = 0 even in IDLE.
- Reset mid-dash: assert rst during cycle 3 of a dash -> next cycle key = 0, busy = 0, no done pulse; x_ready = 1 on the first cycle after rst is released.

Source files
------------

// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared Morse symbol codes, unit lengths and keying states
package morse_pkg;

  // Code word width shared with the coder and decoder stages
  localparam int CW_W = 24;

  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b11;

  // Element and gap lengths in Morse time units
  localparam logic [2:0] DOT_U      = 3'd1;
  localparam logic [2:0] DASH_U     = 3'd3;
  localparam logic [2:0] ELEM_GAP_U = 3'd1;
  localparam logic [2:0] CHAR_GAP_U = 3'd3;
  localparam logic [2:0] WORD_GAP_U = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    ELEM_ON,
    ELEM_GAP,
    CHAR_GAP,
    WORD_GAP
  } morse_state_t;

  // A slot carries a keyed element only for dot or dash; anything else terminates
  function automatic logic is_mark(input logic [1:0] sym);
    return (sym == SYM_DOT) || (sym == SYM_DASH);
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// rtl/morse_unit_timer.sv - unit prescaler plus unit counter for element/gap timing
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       restart,
  input  logic [2:0] len_units,
  output logic       expire
);

  localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

  logic [PW-1:0] pre;
  logic [2:0]    units;
  logic          tick;

  assign tick = (pre == PW'(UNIT_CYCLES - 1));

  // Not gated by en so a frozen final cycle keeps reporting expiry (done holds)
  assign expire = tick & (units == len_units - 3'd1);

  // Prescaler wraps each unit; unit counter advances on every prescaler wrap
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      pre   <= '0;
      units <= '0;
    end else if (en) begin
      if (tick) begin
        pre   <= '0;
        units <= units + 3'd1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_tx.sv
// rtl/morse_tx.sv - plays 24-bit Morse code words out as a timed key line
module morse_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 4,
  parameter int MAX_SYM     = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            x_valid,
  input  logic [CW_W-1:0] x,
  output logic            x_ready,
  output logic            key,
  output logic            busy,
  output logic            done
);

  morse_state_t    state;
  morse_state_t    state_next;
  logic [CW_W-1:0] sreg;
  logic [3:0]      sym_cnt;
  logic [2:0]      len_units;
  logic            expire;
  logic            restart;
  logic            accept;
  logic            last_sym;

  assign x_ready = en & (state == IDLE) & ~rst;
  assign accept  = x_valid & x_ready;
  assign busy    = (state != IDLE);
  assign done    = ~rst & expire & ((state == CHAR_GAP) || (state == WORD_GAP));
  assign restart = (state_next != state);

  // Stop after the slot limit or when the following slot is not a dot/dash
  assign last_sym = (sym_cnt >= 4'(MAX_SYM - 1)) | ~is_mark(sreg[CW_W-3 -: 2]);

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .restart   (restart),
    .len_units (len_units),
    .expire    (expire)
  );

  // Length of the current state in units; the active symbol sits in the top slot
  always_comb begin
    len_units = DOT_U;
    case (state)
      ELEM_ON:  len_units = (sreg[CW_W-1 -: 2] == SYM_DASH) ? DASH_U : DOT_U;
      ELEM_GAP: len_units = ELEM_GAP_U;
      CHAR_GAP: len_units = CHAR_GAP_U;
      WORD_GAP: len_units = WORD_GAP_U;
      default:  len_units = DOT_U;
    endcase
  end

  // Next-state decode; nothing moves while en is low
  always_comb begin
    state_next = state;
    if (en) begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (x == '0)                     state_next = WORD_GAP;
            else if (is_mark(x[CW_W-1 -: 2])) state_next = ELEM_ON;
            else                              state_next = CHAR_GAP;
          end
        end
        ELEM_ON:  if (expire) state_next = last_sym ? CHAR_GAP : ELEM_GAP;
        ELEM_GAP: if (expire) state_next = ELEM_ON;
        CHAR_GAP: if (expire) state_next = IDLE;
        WORD_GAP: if (expire) state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Shift register, symbol count and registered key line
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg    <= '0;
      sym_cnt <= '0;
      key     <= 1'b0;
    end else if (en) begin
      key <= (state_next == ELEM_ON);
      if (accept) begin
        sreg    <= x;
        sym_cnt <= '0;
      end else if ((state == ELEM_ON) && expire) begin
        sreg    <= {sreg[CW_W-3:0], 2'b00};
        sym_cnt <= sym_cnt + 4'd1;
      end
    end
  end

endmodule
